// File: rtl/out_mem_pkg.sv
// Shared types and constants for the output-memory drain path.
package out_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM,
        DONE
    } rd_state_t;

    // Words delivered by one memory access (one quad).
    localparam int unsigned LANES  = 4;
    localparam int unsigned LANE_W = $clog2(LANES);

    // Depth of out_mem in words; readers wrap addresses against this.
    localparam int unsigned OUT_MEM_DEPTH = 128;

    // Lane that follows l inside a quad.
    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] l);
        return l + LANE_W'(1);
    endfunction

endpackage

// File: rtl/out_mem_reader_if.sv
// Memory read bus and word stream of the output-memory reader.
// master = reader side, slave = memory/sink side.
interface out_mem_reader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd1;
    logic [DATA_W-1:0] mem_rd2;
    logic [DATA_W-1:0] mem_rd3;
    logic [DATA_W-1:0] mem_rd4;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_addr,
        input  mem_rd1,
        input  mem_rd2,
        input  mem_rd3,
        input  mem_rd4,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  mem_addr,
        output mem_rd1,
        output mem_rd2,
        output mem_rd3,
        output mem_rd4,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/out_mem_reader_quad_serializer.sv
// Holds one fetched quad and plays it out one word per transfer over a
// valid/ready handshake. The owning FSM strobes load_i during the fetch
// cycle and raises stop_i when the word now on offer is the last one it
// wants from this quad.
module quad_serializer
    import out_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] rd0_i,
    input  logic [DATA_W-1:0] rd1_i,
    input  logic [DATA_W-1:0] rd2_i,
    input  logic [DATA_W-1:0] rd3_i,
    input  logic              out_ready_i,
    input  logic              stop_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    output logic              fire_o,
    output logic              last_lane_o
);

    logic [DATA_W-1:0] quad_q [LANES];
    logic [LANE_W-1:0] lane_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    assign fire_o      = valid_q && out_ready_i;
    assign last_lane_o = (lane_q == LANE_W'(LANES - 1));
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

    // Capture the quad on load, then advance one lane per accepted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                quad_q[i] <= '0;
            end
            lane_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            quad_q[0] <= rd0_i;
            quad_q[1] <= rd1_i;
            quad_q[2] <= rd2_i;
            quad_q[3] <= rd3_i;
            lane_q    <= '0;
            data_q    <= rd0_i;
            valid_q   <= 1'b1;
        end else if (fire_o) begin
            if (stop_i) begin
                valid_q <= 1'b0;
            end else begin
                lane_q <= next_lane(lane_q);
                data_q <= quad_q[next_lane(lane_q)];
            end
        end
    end

endmodule

// File: rtl/out_mem_reader.sv
// Drains the vector output memory after a job: reads one 4-word quad per
// access from out_mem's combinational read ports and streams the words
// one at a time to the host/UART dump path.
module out_mem_reader
    import out_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = OUT_MEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_count,
    output logic              busy,
    output logic              done,
    out_mem_reader_if.master  bus
);

    localparam int unsigned   AW1     = ADDR_W + 1;
    localparam logic [AW1-1:0] DEPTH_X = AW1'(DEPTH);

    rd_state_t         state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       remaining_q;
    logic              busy_q;
    logic              done_q;

    logic [AW1-1:0]    step_sum;
    logic [ADDR_W-1:0] next_quad_addr;
    logic [ADDR_W-1:0] base_wrapped;

    logic              load;
    logic              stop;
    logic              fire;
    logic              last_lane;

    // Address arithmetic: cur_addr is always < DEPTH, so one conditional
    // subtract wraps the quad step; the extra bit keeps the sum from overflowing.
    always_comb begin
        step_sum       = {1'b0, cur_addr_q} + AW1'(LANES);
        next_quad_addr = (step_sum >= DEPTH_X) ? ADDR_W'(step_sum - DEPTH_X)
                                               : ADDR_W'(step_sum);
        base_wrapped   = ADDR_W'({1'b0, base_addr} % DEPTH_X);
    end

    // The word on offer ends the quad either because the job runs out of
    // words or because lane 3 has been reached.
    assign load = (state_q == FETCH);
    assign stop = (remaining_q == 16'd1) || last_lane;

    // Drain sequencer: owns the state, quad address and words-left counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        cur_addr_q  <= base_wrapped;
                        remaining_q <= word_count;
                        if (word_count == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            mem_addr_q <= base_wrapped;
                            busy_q     <= 1'b1;
                            state_q    <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    state_q <= STREAM;
                end
                STREAM: begin
                    if (fire) begin
                        remaining_q <= remaining_q - 16'd1;
                        if (remaining_q == 16'd1) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (last_lane) begin
                            cur_addr_q <= next_quad_addr;
                            mem_addr_q <= next_quad_addr;
                            state_q    <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    quad_serializer #(
        .DATA_W(DATA_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .rd0_i       (bus.mem_rd1),
        .rd1_i       (bus.mem_rd2),
        .rd2_i       (bus.mem_rd3),
        .rd3_i       (bus.mem_rd4),
        .out_ready_i (bus.out_ready),
        .stop_i      (stop),
        .out_data_o  (bus.out_data),
        .out_valid_o (bus.out_valid),
        .fire_o      (fire),
        .last_lane_o (last_lane)
    );

    assign bus.mem_addr = mem_addr_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_out_mem_reader.sv
// Randomized scoreboard bench for out_mem_reader.
module tb_out_mem_reader;

    localparam int unsigned DEPTH = 128;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        busy;
    logic        done;

    logic [31:0] mem [DEPTH];
    exp_t        exp_q [$];

    int          checks;
    int          errors;
    int          xfer_cnt;
    int          done_cnt;
    bit          valid_seen;
    bit          hold_pending;
    logic [31:0] hold_data;
    bit          prev_done;

    out_mem_reader_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    out_mem_reader #(
        .DATA_W(32),
        .ADDR_W(32),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    // Combinational memory model: lanes wrap modulo DEPTH.
    assign bus.mem_rd1 = mem[7'(bus.mem_addr[6:0] + 7'd0)];
    assign bus.mem_rd2 = mem[7'(bus.mem_addr[6:0] + 7'd1)];
    assign bus.mem_rd3 = mem[7'(bus.mem_addr[6:0] + 7'd2)];
    assign bus.mem_rd4 = mem[7'(bus.mem_addr[6:0] + 7'd3)];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer, checks hold behaviour
    // under backpressure and that done is a single-cycle pulse.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 0;
            prev_done    = 0;
        end else begin
            if (bus.out_valid) valid_seen = 1;
            if (hold_pending) begin
                chk_eq("hold_valid", bus.out_valid, 1);
                chk_eq("hold_data", bus.out_data, hold_data);
                hold_pending = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got data %0d with no word outstanding", bus.out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk_eq("word_data", bus.out_data, e.data);
                    chk_eq("quad_addr", bus.mem_addr, e.addr);
                end
            end else if (bus.out_valid && !bus.out_ready) begin
                hold_pending = 1;
                hold_data    = bus.out_data;
            end
            if (done) begin
                chk_eq("done_width", prev_done, 0);
                done_cnt++;
            end
            prev_done = done;
        end
    end

    // Reference: word i of a job comes from (base mod DEPTH + i) mod DEPTH,
    // and the quad it belongs to starts at (base mod DEPTH + 4*(i/4)) mod DEPTH.
    task automatic push_expected(input logic [31:0] b, input int unsigned n);
        longint unsigned bm;
        bm = longint'(b) % DEPTH;
        for (int unsigned i = 0; i < n; i++) begin
            exp_t e;
            e.addr = 32'((bm + (i / 4) * 4) % DEPTH);
            e.data = mem[(bm + i) % DEPTH];
            exp_q.push_back(e);
        end
    endtask

    function automatic logic ready_for(input int mode, input int unsigned idx);
        if (mode == 1) return (idx % 3) == 0;
        if (mode == 2) return 1'($urandom_range(0, 1));
        return 1'b1;
    endfunction

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_job(input logic [31:0] b, input int unsigned cnt,
                           input int mode, input bit inject);
        int unsigned cyc;
        int unsigned bound;
        bit          got_done;
        push_expected(b, cnt);
        valid_seen = 0;
        bound      = 64 * cnt + 20;
        @(posedge clk); #1;
        start         = 1'b1;
        base_addr     = b;
        word_count    = 16'(cnt);
        bus.out_ready = ready_for(mode, 0);
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = 16'($urandom_range(1, 40));
        cyc        = 0;
        got_done   = done;
        if (cnt > 0) begin
            chk_eq("busy_after_start", busy, 1);
            chk_eq("valid_during_fetch", bus.out_valid, 0);
        end
        while (!got_done && cyc < bound) begin
            bus.out_ready = ready_for(mode, cyc + 1);
            if (inject) begin
                start      = (cyc == 3);
                base_addr  = 32'd50;
                word_count = 16'd3;
            end
            @(posedge clk); #1;
            cyc++;
            if (mode == 0 && cyc == 1 && cnt > 0) chk_eq("first_valid_latency", bus.out_valid, 1);
            got_done = done;
        end
        start = 1'b0;
        chk_eq("done_seen", got_done, 1);
        if (mode == 0) chk_eq("done_latency", cyc, cnt + (cnt + 3) / 4);
        chk_eq("words_outstanding", exp_q.size(), 0);
        if (cnt == 0) chk_eq("zero_job_valid", valid_seen, 0);
        @(posedge clk); #1;
        chk_eq("done_cleared", done, 0);
        chk_eq("busy_cleared", busy, 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk_eq({tag, "_valid"}, bus.out_valid, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_done"}, done, 0);
        chk_eq({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk_eq({tag, "_out_data"}, bus.out_data, 0);
    endtask

    task automatic reset_mid_stream();
        int x0;
        int dsnap;
        int unsigned cyc;
        push_expected(32'd20, 2);
        x0 = xfer_cnt;
        @(posedge clk); #1;
        start         = 1'b1;
        base_addr     = 32'd20;
        word_count    = 16'd8;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while ((xfer_cnt - x0) < 2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk_eq("transfers_before_reset", xfer_cnt - x0, 2);
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst   = 1'b0;
        dsnap = done_cnt;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_eq("no_done_after_reset", done_cnt, dsnap);
        chk_eq("no_stream_after_reset", bus.out_valid, 0);
        chk_eq("reset_words_outstanding", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        errors        = 0;
        xfer_cnt      = 0;
        done_cnt      = 0;
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        word_count    = '0;
        bus.out_ready = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mem[0] = 32'd10;
        mem[1] = 32'd11;
        mem[2] = 32'd12;
        mem[3] = 32'd13;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        run_job(32'd0,   4, 0, 0);   // single full quad
        run_job(32'd4,   8, 0, 0);   // two quads with fetch bubble
        run_job(32'd40,  6, 1, 0);   // partial quad under backpressure
        run_job(32'd126, 4, 0, 0);   // lanes wrap past the top
        run_job(32'd124, 8, 0, 0);   // second quad base wraps to 0
        run_job(32'd7,   0, 0, 0);   // empty job
        run_job(32'd60,  7, 0, 1);   // start while busy is ignored
        run_job(32'd300, 5, 0, 0);   // base beyond DEPTH
        reset_mid_stream();
        run_job(32'd33,  9, 0, 0);   // clean run after reset

        for (int unsigned t = 0; t < 12; t++) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] = $urandom;
            run_job($urandom, $urandom_range(1, 20), 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
